// File: rtl/uart_bus_master_if.sv
// Single-word valid/ready memory bus between one initiator and its responders.
interface uart_bus_master_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/uart_bus_master.sv
// UART (8N1) debug bridge: host command frames become single-word bus
// reads/writes; ACK, NAK or read data are returned on tx.
module uart_bus_master #(
  parameter int unsigned CLKDIV  = 104,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   rx,
  output logic                   tx,
  output logic                   busy,
  uart_bus_master_if.master      bus
);

  localparam logic [15:0] DIV_LAST  = 16'(CLKDIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKDIV / 2 - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [7:0]  ACK = 8'h06;
  localparam logic [7:0]  NAK = 8'h15;

  localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_DATA = 3'd2,
                         S_BUS  = 3'd3, S_RESP = 3'd4;
  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1,
                         RX_DATA = 2'd2, RX_STOP  = 2'd3;

  // ---------------- receiver ----------------
  logic       rx_meta, rx_sync, rx_d;
  logic [1:0] rx_st;
  logic [15:0] rx_cnt;
  logic [2:0] rx_bitn;
  logic [7:0] rx_byte;
  logic       rx_done, rx_ferr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_d    <= 1'b1;
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      rx_bitn <= '0;
      rx_byte <= '0;
      rx_done <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_d    <= rx_sync;
      rx_done <= 1'b0;
      case (rx_st)
        RX_IDLE:
          if (!rx_sync && rx_d) begin
            rx_st  <= RX_START;
            rx_cnt <= '0;
          end
        RX_START:
          if (rx_cnt == HALF_LAST) begin
            rx_cnt  <= '0;
            rx_bitn <= '0;
            rx_st   <= rx_sync ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + 16'd1;
        RX_DATA:
          if (rx_cnt == DIV_LAST) begin
            rx_cnt  <= '0;
            rx_byte <= {rx_sync, rx_byte[7:1]};
            if (rx_bitn == 3'd7) rx_st <= RX_STOP;
            else rx_bitn <= rx_bitn + 3'd1;
          end else rx_cnt <= rx_cnt + 16'd1;
        default:
          if (rx_cnt == DIV_LAST) begin
            rx_cnt  <= '0;
            rx_done <= 1'b1;
            rx_ferr <= !rx_sync;
            rx_st   <= RX_IDLE;
          end else rx_cnt <= rx_cnt + 16'd1;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  logic        tx_req;
  logic [31:0] tx_req_data;
  logic [1:0]  tx_req_extra;
  logic        tx_act;
  logic [9:0]  tx_shift;
  logic [23:0] tx_pend;
  logic [1:0]  tx_left;
  logic [3:0]  tx_bitn;
  logic [15:0] tx_cnt;
  logic        tx_done;

  // Queued bytes reload straight from the stop bit so replies carry no idle gap.
  assign tx_done = tx_act && (tx_cnt == DIV_LAST) && (tx_bitn == 4'd9) && (tx_left == 2'd0);
  assign tx      = tx_shift[0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_act   <= 1'b0;
      tx_shift <= '1;
      tx_pend  <= '0;
      tx_left  <= '0;
      tx_bitn  <= '0;
      tx_cnt   <= '0;
    end else if (!tx_act) begin
      if (tx_req) begin
        tx_act   <= 1'b1;
        tx_shift <= {1'b1, tx_req_data[7:0], 1'b0};
        tx_pend  <= tx_req_data[31:8];
        tx_left  <= tx_req_extra;
        tx_bitn  <= '0;
        tx_cnt   <= '0;
      end
    end else if (tx_cnt == DIV_LAST) begin
      tx_cnt <= '0;
      if (tx_bitn == 4'd9) begin
        tx_bitn <= '0;
        if (tx_left != 2'd0) begin
          tx_shift <= {1'b1, tx_pend[7:0], 1'b0};
          tx_pend  <= {8'h00, tx_pend[23:8]};
          tx_left  <= tx_left - 2'd1;
        end else begin
          tx_act   <= 1'b0;
          tx_shift <= '1;
        end
      end else begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_bitn  <= tx_bitn + 4'd1;
      end
    end else tx_cnt <= tx_cnt + 16'd1;
  end

  // ---------------- command / bus FSM ----------------
  logic [2:0]  state;
  logic        is_write;
  logic [1:0]  byte_cnt;
  logic        valid_q;
  logic [3:0]  wstrb_q;
  logic [31:0] addr_q, wdata_q;
  logic [15:0] to_cnt;
  logic        busy_q;

  assign bus.valid = valid_q;
  assign bus.wstrb = wstrb_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      is_write     <= 1'b0;
      byte_cnt     <= '0;
      valid_q      <= 1'b0;
      wstrb_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      to_cnt       <= '0;
      busy_q       <= 1'b0;
      tx_req       <= 1'b0;
      tx_req_data  <= '0;
      tx_req_extra <= '0;
    end else begin
      tx_req <= 1'b0;
      if (tx_done) busy_q <= 1'b0;
      case (state)
        S_IDLE:
          if (rx_done) begin
            if (!rx_ferr && (rx_byte == 8'h57 || rx_byte == 8'h52)) begin
              is_write <= (rx_byte == 8'h57);
              byte_cnt <= '0;
              state    <= S_ADDR;
            end else begin
              tx_req       <= 1'b1;
              tx_req_data  <= {24'h0, NAK};
              tx_req_extra <= '0;
            end
          end
        S_ADDR, S_DATA:
          if (rx_done) begin
            if (rx_ferr) begin
              state        <= S_IDLE;
              tx_req       <= 1'b1;
              tx_req_data  <= {24'h0, NAK};
              tx_req_extra <= '0;
            end else begin
              if (state == S_ADDR) begin
                addr_q <= {rx_byte, addr_q[31:8]};
                if (byte_cnt == 2'd0) busy_q <= 1'b1;
              end else wdata_q <= {rx_byte, wdata_q[31:8]};
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                if (state == S_ADDR && is_write) state <= S_DATA;
                else begin
                  state   <= S_BUS;
                  valid_q <= 1'b1;
                  wstrb_q <= is_write ? 4'hF : 4'h0;
                  to_cnt  <= '0;
                end
              end
            end
          end
        S_BUS:
          if (valid_q && bus.ready) begin
            valid_q      <= 1'b0;
            wstrb_q      <= '0;
            tx_req       <= 1'b1;
            tx_req_data  <= is_write ? {24'h0, ACK} : bus.rdata;
            tx_req_extra <= is_write ? 2'd0 : 2'd3;
            state        <= S_RESP;
          end else if (to_cnt == TO_LAST) begin
            valid_q      <= 1'b0;
            wstrb_q      <= '0;
            tx_req       <= 1'b1;
            tx_req_data  <= {24'h0, NAK};
            tx_req_extra <= '0;
            state        <= S_RESP;
          end else to_cnt <= to_cnt + 16'd1;
        S_RESP:
          if (tx_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: UART host frames in, bus responder model, tx bytes decoded.
module tb_uart_bus_master;
  localparam int unsigned DIV = 4;
  localparam int unsigned TO  = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rx = 1'b1;
  logic tx, busy;

  uart_bus_master_if bus();

  int mode = 2;               // 0: ready with valid, 1: ready 2 cycles later, 2: never
  int vcnt = 0;
  logic [31:0] tb_rdata = '0;

  assign bus.ready = bus.valid && (mode == 0 || (mode == 1 && vcnt == 2));
  assign bus.rdata = tb_rdata;

  uart_bus_master #(.CLKDIV(DIV), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .rx(rx), .tx(tx), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) vcnt <= bus.valid ? vcnt + 1 : 0;

  // bus / line monitor
  int pulses = 0, cur_len = 0, last_len = 0, tx_low = 0, instab = 0;
  logic prev_valid = 1'b0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  always @(negedge clk) begin
    prev_valid <= bus.valid;
    if (!tx) tx_low <= tx_low + 1;
    if (bus.valid) begin
      cur_len   <= cur_len + 1;
      cap_addr  <= bus.addr;
      cap_wdata <= bus.wdata;
      cap_wstrb <= bus.wstrb;
      if (prev_valid && (bus.addr != cap_addr || bus.wdata != cap_wdata || bus.wstrb != cap_wstrb))
        instab <= instab + 1;
    end else if (prev_valid) begin
      pulses   <= pulses + 1;
      last_len <= cur_len;
      cur_len  <= 0;
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic get_byte(output logic [7:0] b, output int t0, output bit ok);
    ok = 1'b0;
    b  = '0;
    t0 = 0;
    for (int w = 0; w < 600; w++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    t0 = cyc;
    repeat (DIV / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      b[i] = tx;
    end
    repeat (DIV) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  typedef struct {
    logic        is_wr;
    logic [31:0] a;
    logic [31:0] d;
    int          md;
    logic [31:0] rd;
    int          nb;
    logic [31:0] resp;
    int          plen;
  } vec_t;

  vec_t v[4];

  task automatic expect_bytes(input int nb, input logic [31:0] resp);
    logic [7:0] b;
    int t, tprev;
    bit ok;
    tprev = 0;
    for (int k = 0; k < nb; k++) begin
      get_byte(b, t, ok);
      chk("resp_framed", 32'(ok), 32'd1);
      chk("resp_byte", 32'(b), 32'(resp[8*k +: 8]));
      if (k > 0) chk("resp_gap", 32'(t - tprev), 32'(DIV * 10));
      tprev = t;
    end
  endtask

  task automatic run_vec(input vec_t x);
    int p0;
    mode     = x.md;
    tb_rdata = x.rd;
    p0       = pulses;
    send_byte(x.is_wr ? 8'h57 : 8'h52, 1'b1);
    for (int k = 0; k < 4; k++) send_byte(x.a[8*k +: 8], 1'b1);
    if (x.is_wr) for (int k = 0; k < 4; k++) send_byte(x.d[8*k +: 8], 1'b1);
    chk("busy_in_txn", 32'(busy), 32'd1);
    expect_bytes(x.nb, x.resp);
    repeat (DIV + 1) @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    chk("valid_pulses", 32'(pulses - p0), 32'd1);
    chk("valid_len", 32'(last_len), 32'(x.plen));
    chk("addr", cap_addr, x.a);
    chk("wstrb", 32'(cap_wstrb), x.is_wr ? 32'hF : 32'h0);
    if (x.is_wr) chk("wdata", cap_wdata, x.d);
    chk("bus_stable", 32'(instab), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, tl0;
    //             wr    addr           data           md rdata          nb resp           len
    v[0] = '{1'b1, 32'h0200_0010, 32'hDEAD_BEEF, 1, 32'h0000_0000, 1, 32'h0000_0006, 3};
    v[1] = '{1'b0, 32'h0200_0004, 32'h0000_0000, 0, 32'h1234_5678, 4, 32'h1234_5678, 1};
    v[2] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 2, 32'hCAFE_F00D, 1, 32'h0000_0015, 16};
    v[3] = '{1'b0, 32'h8000_00FC, 32'h0000_0000, 1, 32'hA5C3_0F96, 4, 32'hA5C3_0F96, 3};

    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_wstrb", 32'(bus.wstrb), 32'd0);
    chk("rst_addr", bus.addr, 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_vec(v[i]);
      repeat (8) @(negedge clk);
    end

    // unknown command byte
    p0 = pulses;
    send_byte(8'h41, 1'b1);
    expect_bytes(1, 32'h15);
    repeat (8) @(negedge clk);

    // framing error on the third byte of a write frame
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b0);
    expect_bytes(1, 32'h15);
    repeat (DIV + 1) @(negedge clk);
    chk("ferr_no_valid", 32'(pulses - p0), 32'd0);
    chk("ferr_busy", 32'(busy), 32'd0);

    // short glitch while idle
    repeat (8) @(negedge clk);
    tl0 = tx_low;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (80) @(negedge clk);
    chk("glitch_tx_quiet", 32'(tx_low - tl0), 32'd0);
    chk("glitch_busy", 32'(busy), 32'd0);

    // reset while a write is waiting on the bus
    mode = 2;
    send_byte(8'h57, 1'b1);
    for (int k = 0; k < 4; k++) send_byte(8'h11 * 8'(k + 1), 1'b1);
    for (int k = 0; k < 4; k++) send_byte(8'hA0 + 8'(k), 1'b1);
    for (int w = 0; w < 50 && !bus.valid; w++) @(negedge clk);
    chk("rst_mid_valid_seen", 32'(bus.valid), 32'd1);
    repeat (3) @(negedge clk);
    tl0 = tx_low;
    resetn = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.valid), 32'd0);
    chk("rst_mid_wstrb", 32'(bus.wstrb), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_tx", 32'(tx), 32'd1);
    repeat (10) @(negedge clk);
    resetn = 1'b1;
    repeat (60) @(negedge clk);
    chk("rst_mid_no_resp", 32'(tx_low - tl0), 32'd0);
    run_vec(v[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
